// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for a small RV32I-subset core. It sequences FETCH/DECODE/EXEC/MEM/WB,
// drives the memory handshake and datapath strobes, traps on an illegal opcode, and counts
// retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        busy,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd6,
    StUnused = 3'd7
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;

  state_e      state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [31:0] instret_q, instret_d;
  logic        opcode_legal;
  logic        op_is_load, op_is_store, op_is_branch;

  // Legality is judged on the live opcode while in DECODE.
  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OpLoad, OpStore, OpImm, OpReg, OpLui, OpJal, OpJalr, OpBranch: opcode_legal = 1'b1;
      default:                                                      opcode_legal = 1'b0;
    endcase
  end

  // EXEC and MEM steer from the latched opcode so a changing opcode input cannot disturb them.
  assign op_is_load   = (op_q == OpLoad);
  assign op_is_store  = (op_q == OpStore);
  assign op_is_branch = (op_q == OpBranch);

  // Next-state and strobe decode; only ir_we/pc_we in FETCH/MEM look at mem_ready.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    busy     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        busy    = 1'b1;
        op_d    = opcode;
        state_d = opcode_legal ? StExec : StTrap;
      end
      StExec: begin
        busy = 1'b1;
        if (op_is_load || op_is_store) begin
          state_d = StMem;
        end else if (op_is_branch) begin
          pc_we   = 1'b1;
          state_d = StFetch;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = op_is_store;
        if (mem_ready) begin
          if (op_is_store) begin
            pc_we   = 1'b1;
            state_d = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        busy    = 1'b1;
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // One retire per pc_we pulse, visible the following cycle; wraps silently.
  always_comb begin
    instret_d = instret_q + {31'd0, pc_we};
  end

  // State, latched opcode and retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= 7'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instret_q <= instret_d;
    end
  end

  assign illegal = (state_q == StTrap);
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected state/strobe tables per scenario.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, busy, illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  multicycle_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addr_sel  (addr_sel),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .reg_we    (reg_we),
    .busy      (busy),
    .illegal   (illegal),
    .state     (state),
    .instret   (instret)
  );

  always #5 clk = ~clk;

  // Packed view: {state, mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, busy, illegal}
  function automatic logic [10:0] obs();
    return {state, mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, busy, illegal};
  endfunction

  // Pulse reset away from a clock edge, then align to just after a rising edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; opcode = OpReg; mem_ready = 1'b1;
    #3;
    total++;
    if (obs() !== 11'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", obs(), 11'd0);
    end
    total++;
    if (instret !== 32'd0) begin
      bad++; $display("FAIL reset_instret got=%h want=%h", instret, 32'd0);
    end
    @(posedge clk); #1;
    total++;
    if (state !== 3'd0) begin
      bad++; $display("FAIL reset_hold got=%0d want=0", state);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    logic [10:0] exp [6];
    exp = '{{3'd0, 8'b0000_0000}, {3'd1, 8'b1001_0010}, {3'd2, 8'b0000_0010},
            {3'd3, 8'b0000_0010}, {3'd5, 8'b0000_1110}, {3'd1, 8'b1001_0010}};
    apply_reset();
    opcode = OpReg; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start = (i == 0);
      @(negedge clk);
      total++;
      if (obs() !== exp[i]) begin
        bad++; $display("FAIL rtype cyc=%0d got=%h want=%h", i, obs(), exp[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 32'd1) begin
      bad++; $display("FAIL rtype_instret got=%0d want=1", instret);
    end
  endtask

  task automatic test_load_wait();
    logic [10:0] exp [9];
    bit          rdy [9];
    exp = '{{3'd0, 8'b0000_0000}, {3'd1, 8'b1001_0010}, {3'd2, 8'b0000_0010},
            {3'd3, 8'b0000_0010}, {3'd4, 8'b1010_0010}, {3'd4, 8'b1010_0010},
            {3'd4, 8'b1010_0010}, {3'd5, 8'b0000_1110}, {3'd1, 8'b1001_0010}};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    apply_reset();
    opcode = OpLoad;
    for (int i = 0; i < 9; i++) begin
      start = (i == 0); mem_ready = rdy[i];
      @(negedge clk);
      total++;
      if (obs() !== exp[i]) begin
        bad++; $display("FAIL load_wait cyc=%0d got=%h want=%h", i, obs(), exp[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 32'd1) begin
      bad++; $display("FAIL load_instret got=%0d want=1", instret);
    end
  endtask

  task automatic test_store();
    logic [10:0] exp [7];
    bit          rdy [7];
    exp = '{{3'd0, 8'b0000_0000}, {3'd1, 8'b1000_0010}, {3'd1, 8'b1001_0010},
            {3'd2, 8'b0000_0010}, {3'd3, 8'b0000_0010}, {3'd4, 8'b1110_1010},
            {3'd1, 8'b1001_0010}};
    rdy = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    apply_reset();
    opcode = OpStore;
    for (int i = 0; i < 7; i++) begin
      start = (i == 0); mem_ready = rdy[i];
      @(negedge clk);
      total++;
      if (obs() !== exp[i]) begin
        bad++; $display("FAIL store cyc=%0d got=%h want=%h", i, obs(), exp[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 32'd1) begin
      bad++; $display("FAIL store_instret got=%0d want=1", instret);
    end
  endtask

  // Branch then jal back to back; live opcode is scrambled during EXEC to expose op_q use.
  task automatic test_back_to_back();
    logic [10:0] exp [9];
    logic [6:0]  opc [9];
    exp = '{{3'd0, 8'b0000_0000}, {3'd1, 8'b1001_0010}, {3'd2, 8'b0000_0010},
            {3'd3, 8'b0000_1010}, {3'd1, 8'b1001_0010}, {3'd2, 8'b0000_0010},
            {3'd3, 8'b0000_0010}, {3'd5, 8'b0000_1110}, {3'd1, 8'b1001_0010}};
    opc = '{OpBranch, OpBranch, OpBranch, OpLoad, OpJal, OpJal, OpBranch, OpJal, OpJal};
    apply_reset();
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      start = (i == 0); opcode = opc[i];
      @(negedge clk);
      total++;
      if (obs() !== exp[i]) begin
        bad++; $display("FAIL b2b cyc=%0d got=%h want=%h", i, obs(), exp[i]);
      end
      @(posedge clk); #1;
    end
    total++;
    if (instret !== 32'd2) begin
      bad++; $display("FAIL b2b_instret got=%0d want=2", instret);
    end
  endtask

  task automatic test_illegal();
    logic [10:0] exp [6];
    exp = '{{3'd0, 8'b0000_0000}, {3'd1, 8'b1001_0010}, {3'd2, 8'b0000_0010},
            {3'd6, 8'b0000_0001}, {3'd6, 8'b0000_0001}, {3'd6, 8'b0000_0001}};
    apply_reset();
    opcode = OpFence; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start = (i == 0) || (i >= 3);
      @(negedge clk);
      total++;
      if (obs() !== exp[i]) begin
        bad++; $display("FAIL illegal cyc=%0d got=%h want=%h", i, obs(), exp[i]);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 11'd0) begin
      bad++; $display("FAIL illegal_clear got=%h want=%h", obs(), 11'd0);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset();
    opcode = OpBranch; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd1 || mem_req !== 1'b1 || instret !== 32'd1) begin
      bad++; $display("FAIL midfetch_pre got=%0d/%b/%0d want=1/1/1", state, mem_req, instret);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 11'd0 || instret !== 32'd0) begin
      bad++; $display("FAIL midfetch_rst got=%h/%0d want=000/0", obs(), instret);
    end
    #4;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (state !== 3'd0 || instret !== 32'd0) begin
        bad++; $display("FAIL midfetch_idle got=%0d/%0d want=0/0", state, instret);
      end
    end
  endtask

  // Counter preloaded near the top, then ten branch retires carry it through zero.
  task automatic test_wrap();
    logic [31:0] want;
    apply_reset();
    force dut.instret_q = 32'hFFFF_FFF8;
    #1;
    release dut.instret_q;
    total++;
    if (instret !== 32'hFFFF_FFF8) begin
      bad++; $display("FAIL wrap_preload got=%h want=%h", instret, 32'hFFFF_FFF8);
    end
    opcode = OpBranch; mem_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      want = 32'hFFFF_FFF8 + 32'(k);
      @(negedge clk);
      total++;
      if (state !== 3'd1 || instret !== want) begin
        bad++; $display("FAIL wrap k=%0d got=%0d/%h want=1/%h", k, state, instret, want);
      end
      repeat (3) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_back_to_back();
    test_illegal();
    test_reset_mid_fetch();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  begin execution; sampled only in IDLE.
REQ-005 opcode  input  7  instr[6:0] from the instruction register, valid from DECODE onward.
REQ-006 mem_ready  input  1  memory completes the requested access this cycle.
REQ-007 mem_req  output  1  memory access request, held until mem_ready.
REQ-008 mem_we  output  1  store request, valid only with mem_req.
REQ-009 addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 ir_we  output  1  instruction register load strobe.
REQ-011 pc_we  output  1  PC update strobe; the datapath selects the next-PC source from branch/jump.
REQ-012 reg_we  output  1  register-file write strobe.
REQ-013 busy  output  1  high in every state except IDLE and TRAP.
REQ-014 illegal  output  1  sticky illegal-opcode flag.
REQ-015 state  output  3  current state encoding.
REQ-016 instret  output  32  retired-instruction counter.

Function
REQ-017 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; code 7 is unreachable and SHALL go to IDLE.
REQ-018 All outputs SHALL be Moore (state-decoded), except ir_we and pc_we in FETCH/MEM, which also depend on mem_ready.
REQ-019 IDLE: start=1 -> FETCH; otherwise stay; start in any other state is ignored.
REQ-020 FETCH: mem_req=1, addr_sel=0, mem_we=0; mem_ready=1 -> ir_we=1 that cycle, next state DECODE; mem_ready=0 -> stay.
REQ-021 DECODE: register opcode into op_q; legal set = 0000011 (load), 0100011 (store), 0010011 (op-imm), 0110011 (op), 0110111 (lui), 1101111 (jal), 1100111 (jalr), 1100011 (branch).
REQ-022 DECODE transition: legal -> EXEC; any other opcode -> TRAP.
REQ-023 EXEC transitions: load/store -> MEM; branch -> pc_we=1 and FETCH; all other opcodes -> WB.
REQ-024 EXEC: op_q SHALL be used, not the live opcode input.
REQ-025 MEM: mem_req=1, addr_sel=1, mem_we=1 only for a store; on mem_ready=1, load -> WB, and store -> pc_we=1 and FETCH.
REQ-026 WB: reg_we=1, pc_we=1 for one cycle, next state FETCH.
REQ-027 TRAP: illegal=1, busy=0, and all strobes 0; the block SHALL remain in TRAP until reset.
REQ-028 Handshake: mem_req, mem_we and addr_sel SHALL stay stable while waiting; mem_ready SHALL be ignored when mem_req=0.
REQ-029 Each pc_we pulse SHALL retire one instruction: instret increments by 1 in the following cycle.
REQ-030 instret SHALL wrap from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-031 Zero-wait-state latency, start of FETCH to the next FETCH: branch 3 cycles, op/op-imm/lui/jal/jalr 4, store 4, load 5.
REQ-032 Each cycle of mem_ready=0 during FETCH or MEM SHALL add exactly one cycle to the latency.
REQ-033 ir_we, pc_we and reg_we SHALL never assert in the same cycle as each other, except pc_we with reg_we in WB.

Reset
REQ-034 rst_n=0 SHALL force state=IDLE, op_q=0, instret=0, illegal=0 and every output strobe to 0 immediately, without waiting for clk.
REQ-035 Reset mid-access (FETCH/MEM with mem_req=1) SHALL drop mem_req at once; no retire SHALL be counted.
REQ-036 After rst_n rises, the block SHALL wait in IDLE for start.

Verification
REQ-037 R-type: start, opcode=0110011, mem_ready=1 always -> states 1,2,3,5,1; reg_we and pc_we together in WB; instret 0 -> 1.
REQ-038 Load with 2 wait states in MEM: opcode=0000011, mem_ready low for 2 cycles -> MEM lasts 3 cycles with addr_sel=1 and mem_we=0, then WB; total 7 cycles.
REQ-039 Store: opcode=0100011 -> mem_we=1 in MEM only; reg_we never asserts; pc_we asserts on the mem_ready cycle; instret +1.
REQ-040 Illegal: opcode=0001111 -> DECODE then TRAP; illegal=1, busy=0; start pulses are ignored; rst_n=0 clears to IDLE with illegal=0.
REQ-041 Reset mid-fetch: rst_n low while FETCH is waiting -> mem_req=0 the same cycle, state=0, instret=0.
REQ-042 Wrap: preload instret to 0xFFFFFFFF via a long branch loop (3-cycle retires) -> the next retire yields 0x00000000.
